multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl.sv | 169 ++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with a sticky
// illegal-opcode trap and a retired-instruction counter.
module multicycle_ctrl #(
  parameter int unsigned RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [6:0]          opcode,
  input  logic                funct7_5,
  input  logic                cero,
  input  logic                mem_ready,
  output logic                ir_we,
  output logic                pc_we,
  output logic                S_Mux_A,
  output logic [1:0]          S_Mux_B,
  output logic [1:0]          S_Mux_C,
  output logic                control_ALU,
  output logic                REG_WR,
  output logic                MEM_RD,
  output logic                MEM_WR,
  output logic                illegal,
  output logic [2:0]          state,
  output logic [RETIRE_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  typedef enum logic [6:0] {
    OP_R     = 7'b0110011,
    OP_IALU  = 7'b0010011,
    OP_LOAD  = 7'b0000011,
    OP_STORE = 7'b0100011,
    OP_BNE   = 7'b1100011,
    OP_LUI   = 7'b0110111
  } opcode_e;

  state_e              state_q, state_d;
  logic [RETIRE_W-1:0] retired_q;
  logic                illegal_q;

  logic       is_r, is_ialu, is_load, is_store, is_bne, is_lui, supported;
  logic [1:0] alu_b;
  logic       alu_sub;

  always_comb begin
    is_r      = (opcode == OP_R);
    is_ialu   = (opcode == OP_IALU);
    is_load   = (opcode == OP_LOAD);
    is_store  = (opcode == OP_STORE);
    is_bne    = (opcode == OP_BNE);
    is_lui    = (opcode == OP_LUI);
    supported = is_r | is_ialu | is_load | is_store | is_bne | is_lui;

    // ALU selects are set up in EXEC and held unchanged through MEM and WB
    alu_b   = 2'b00;
    alu_sub = 1'b0;
    if (is_store) begin
      alu_b = 2'b10;
    end else if (is_ialu || is_load) begin
      alu_b = 2'b01;
    end
    if (is_r) begin
      alu_sub = funct7_5;
    end else if (is_bne) begin
      alu_sub = 1'b1;
    end
  end

  // Outputs are decoded from the state; rst_n gates them so reset silences
  // every strobe immediately, including ir_we although the reset state is FETCH.
  always_comb begin
    state_d     = state_q;
    ir_we       = 1'b0;
    pc_we       = 1'b0;
    S_Mux_A     = 1'b0;
    S_Mux_B     = 2'b00;
    S_Mux_C     = 2'b00;
    control_ALU = 1'b0;
    REG_WR      = 1'b0;
    MEM_RD      = 1'b0;
    MEM_WR      = 1'b0;
    if (rst_n) begin
      unique case (state_q)
        S_FETCH: begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end
        S_DECODE: begin
          state_d = supported ? S_EXEC : S_TRAP;
        end
        S_EXEC: begin
          S_Mux_B     = alu_b;
          control_ALU = alu_sub;
          if (is_bne) begin
            pc_we   = 1'b1;
            S_Mux_A = ~cero;
            state_d = S_FETCH;
          end else if (is_load || is_store) begin
            state_d = S_MEM;
          end else if (is_r || is_ialu || is_lui) begin
            state_d = S_WB;
          end else begin
            state_d = S_TRAP;
          end
        end
        S_MEM: begin
          S_Mux_B     = alu_b;
          control_ALU = alu_sub;
          MEM_RD      = is_load;
          MEM_WR      = ~is_load;
          if (mem_ready) begin
            if (is_load) begin
              state_d = S_WB;
            end else begin
              pc_we   = 1'b1;
              state_d = S_FETCH;
            end
          end
        end
        S_WB: begin
          S_Mux_B     = alu_b;
          control_ALU = alu_sub;
          REG_WR      = 1'b1;
          pc_we       = 1'b1;
          if (is_load) begin
            S_Mux_C = 2'b01;
          end else if (is_lui) begin
            S_Mux_C = 2'b10;
          end
          state_d = S_FETCH;
        end
        S_TRAP: begin
          state_d = S_TRAP;
        end
        default: begin
          state_d = S_FETCH;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (pc_we) begin
        retired_q <= retired_q + RETIRE_W'(1);
      end
      if (state_d == S_TRAP) begin
        illegal_q <= 1'b1;
      end
    end
  end

  assign state   = state_q;
  assign retired = retired_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: each instruction is expanded into its
// expected phase sequence from the latency rules and checked cycle by cycle.
module tb_multicycle_ctrl;

  localparam int unsigned RW    = 4;
  localparam int unsigned RMASK = (1 << RW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [6:0]    opcode = '0;
  logic          funct7_5 = 1'b0;
  logic          cero = 1'b0;
  logic          mem_ready = 1'b0;
  logic          ir_we, pc_we, S_Mux_A, control_ALU, REG_WR, MEM_RD, MEM_WR, illegal;
  logic [1:0]    S_Mux_B, S_Mux_C;
  logic [2:0]    state;
  logic [RW-1:0] retired;

  multicycle_ctrl #(.RETIRE_W(RW)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct7_5(funct7_5), .cero(cero),
    .mem_ready(mem_ready), .ir_we(ir_we), .pc_we(pc_we), .S_Mux_A(S_Mux_A),
    .S_Mux_B(S_Mux_B), .S_Mux_C(S_Mux_C), .control_ALU(control_ALU),
    .REG_WR(REG_WR), .MEM_RD(MEM_RD), .MEM_WR(MEM_WR), .illegal(illegal),
    .state(state), .retired(retired)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] OPS [6] = '{7'b0110011, 7'b0010011, 7'b0000011,
                                     7'b0100011, 7'b1100011, 7'b0110111};

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned ret_model = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [14:0] dut_vec();
    return {ir_we, pc_we, S_Mux_A, S_Mux_B, S_Mux_C, control_ALU,
            REG_WR, MEM_RD, MEM_WR, illegal, state};
  endfunction

  function automatic bit is_supported(input logic [6:0] op);
    foreach (OPS[i]) if (op == OPS[i]) return 1'b1;
    return 1'b0;
  endfunction

  // Phase: 0 fetch, 1 decode, 2 exec, 3 mem, 4 writeback, 5 trap.
  function automatic logic [14:0] exp_vec(input int ph, input logic [6:0] op,
                                          input logic f5, input logic cz, input logic rdy);
    bit ld  = (op == 7'b0000011);
    bit sw  = (op == 7'b0100011);
    bit bne = (op == 7'b1100011);
    bit lui = (op == 7'b0110111);
    bit rr  = (op == 7'b0110011);
    bit ia  = (op == 7'b0010011);
    logic irw = 0, pcw = 0, sa = 0, ctl = 0, rw = 0, mr = 0, mw = 0, ill = 0;
    logic [1:0] sb = 0, sc = 0, selb;
    logic sub;
    selb = sw ? 2'd2 : ((ia || ld) ? 2'd1 : 2'd0);
    sub  = rr ? f5 : logic'(bne);
    case (ph)
      0: irw = 1;
      2: begin sb = selb; ctl = sub; if (bne) begin pcw = 1; sa = ~cz; end end
      3: begin sb = selb; ctl = sub; mr = ld; mw = sw; pcw = sw && rdy; end
      4: begin sb = selb; ctl = sub; rw = 1; pcw = 1; sc = ld ? 2'd1 : (lui ? 2'd2 : 2'd0); end
      5: ill = 1;
      default: ;
    endcase
    return {irw, pcw, sa, sb, sc, ctl, rw, mr, mw, ill, 3'(ph)};
  endfunction

  // Called mid-cycle; releases reset just after a rising edge so the next
  // sampled cycle is the first FETCH.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_eq("reset_outs", 32'(dut_vec()), 32'd0);
    check_eq("reset_retired", 32'(retired), 32'd0);
    ret_model = 0;
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic run_instr(input logic [6:0] op, input logic f5, input logic cz,
                           input int unsigned waits, input int abort_k);
    int ph[$];
    int pcs = 0;
    bit ok = is_supported(op);
    ph.push_back(0);
    ph.push_back(1);
    if (!ok) begin
      for (int j = 0; j < 20; j++) ph.push_back(5);
    end else begin
      ph.push_back(2);
      if (op == 7'b0000011 || op == 7'b0100011)
        for (int unsigned j = 0; j <= waits; j++) ph.push_back(3);
      if (op != 7'b1100011 && op != 7'b0100011) ph.push_back(4);
    end
    for (int k = 0; k < ph.size(); k++) begin
      logic rdy;
      logic [14:0] e;
      @(negedge clk);
      opcode = op; funct7_5 = f5; cero = cz;
      if (ph[k] == 3) rdy = (k == ph.size() - 1) || (ph[k+1] != 3);
      else            rdy = 1'($urandom_range(0, 1));
      mem_ready = rdy;
      #1;
      e = exp_vec(ph[k], op, f5, cz, rdy);
      check_eq("outs", 32'(dut_vec()), 32'(e));
      check_eq("retired", 32'(retired), ret_model & RMASK);
      check_eq("regwr_with_memwr", 32'(REG_WR & MEM_WR), 32'd0);
      pcs += int'(pc_we);
      if (e[13]) ret_model++;
      if (k == abort_k) begin
        do_reset();
        return;
      end
    end
    if (ok) begin
      check_eq("pc_we_once", 32'(pcs), 32'd1);
    end else begin
      check_eq("pc_we_trap", 32'(pcs), 32'd0);
      do_reset();
    end
  endtask

  initial begin
    #1;
    do_reset();
    run_instr(7'b0110011, 1'b1, 1'b0, 0, -1);
    run_instr(7'b0000011, 1'b0, 1'b0, 2, -1);
    run_instr(7'b1100011, 1'b0, 1'b0, 0, -1);
    run_instr(7'b1100011, 1'b0, 1'b1, 0, -1);
    run_instr(7'b0100011, 1'b0, 1'b0, 0, -1);
    run_instr(7'b1111111, 1'b0, 1'b0, 0, -1);
    for (int i = 0; i < 17; i++) run_instr(7'b0110111, 1'($urandom), 1'($urandom), 0, -1);
    @(negedge clk);
    #1;
    check_eq("lui_wrap", 32'(retired), 32'd1);
    do_reset();
    run_instr(7'b0000011, 1'b0, 1'b0, 3, 4);
    run_instr(7'b0100011, 1'b0, 1'b0, 2, 3);
    run_instr(7'b0000011, 1'b0, 1'b0, 0, -1);

    for (int i = 0; i < 300; i++) begin
      logic [6:0] op;
      int ak;
      op = OPS[$urandom_range(0, 5)];
      if ($urandom_range(0, 49) == 0) begin
        do op = 7'($urandom); while (is_supported(op));
      end
      ak = ($urandom_range(0, 39) == 0) ? int'($urandom_range(0, 5)) : -1;
      run_instr(op, 1'($urandom), 1'($urandom), $urandom_range(0, 3), ak);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
